// File: rtl/wshb_if.sv
// wshb_if: Wishbone B4 bus bundle; master drives requests, slave drives responses.
interface wshb_if #(
    parameter int AW = 32,
    parameter int DW = 32
) ();
    logic            cyc;
    logic            stb;
    logic            we;
    logic [AW-1:0]   adr;
    logic [DW-1:0]   dat_w;
    logic [DW/8-1:0] sel;
    logic [2:0]      cti;
    logic [1:0]      bte;
    logic            ack;
    logic            err;
    logic [DW-1:0]   dat_r;
    modport master (output cyc, stb, we, adr, dat_w, sel, cti, bte, input ack, err, dat_r);
    modport slave (input cyc, stb, we, adr, dat_w, sel, cti, bte, output ack, err, dat_r);
endinterface

// File: rtl/wshb_arbiter.sv
// wshb_arbiter: two-master Wishbone B4 arbiter sharing one slave port, round-robin
// with a bounded hold so a long writer burst cannot starve the other master.
module wshb_arbiter #(
    parameter int MAX_HOLD = 64,
    parameter int AW       = 32,
    parameter int DW       = 32
) (
    input  logic       clk,
    input  logic       nrst,
    wshb_if.slave      m0,
    wshb_if.slave      m1,
    wshb_if.master     s,
    output logic [1:0] gnt
);
    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t          state_q, state_d, other;
    logic            last_q, last_d, drop_q, drop_d;
    logic [HW-1:0]   hold_q, hold_d, hold_inc;
    logic            own1, active, cyc_x, cyc_y, stb_x, beat, boundary;
    logic [2:0]      cti_x;
    logic [AW-1:0]   adr_x;
    logic [DW-1:0]   dat_x;
    logic [DW/8-1:0] sel_x;

    if (MAX_HOLD < 1) begin : g_bad_hold
        $error("wshb_arbiter: MAX_HOLD must be at least 1");
    end

    always_comb begin
        own1     = state_q == OWN1;
        // drop_q marks the single bus-idle cycle between a pre-emption and the handoff
        active   = state_q != IDLE && !drop_q;
        cyc_x    = own1 ? m1.cyc : m0.cyc;
        cyc_y    = own1 ? m0.cyc : m1.cyc;
        stb_x    = own1 ? m1.stb : m0.stb;
        cti_x    = own1 ? m1.cti : m0.cti;
        adr_x    = own1 ? m1.adr : m0.adr;
        dat_x    = own1 ? m1.dat_w : m0.dat_w;
        sel_x    = own1 ? m1.sel : m0.sel;
        other    = own1 ? OWN0 : OWN1;
        beat     = active && (s.ack || s.err);
        hold_inc = hold_q == HOLD_MAX ? hold_q : hold_q + HW'(beat);
        boundary = !stb_x || (beat && (cti_x == 3'b000 || cti_x == 3'b111));
        state_d  = state_q;
        last_d   = last_q;
        hold_d   = hold_q;
        drop_d   = 1'b0;
        if (state_q == IDLE) begin
            state_d = m0.cyc && (!m1.cyc || last_q) ? OWN0 : m1.cyc ? OWN1 : IDLE;
            hold_d  = '0;
        end else if (drop_q || !cyc_x) begin
            state_d = cyc_y ? other : (drop_q && cyc_x) ? state_q : IDLE;
            hold_d  = '0;
            last_d  = own1;
        end else begin
            hold_d = hold_inc;
            drop_d = hold_inc == HOLD_MAX && cyc_y && boundary;
        end
        s.cyc    = active && cyc_x;
        s.stb    = active && stb_x;
        s.we     = active && (own1 ? m1.we : m0.we);
        s.adr    = active ? adr_x : '0;
        s.dat_w  = active ? dat_x : '0;
        s.sel    = active ? sel_x : '0;
        s.cti    = active ? cti_x : 3'b000;
        s.bte    = active ? (own1 ? m1.bte : m0.bte) : 2'b00;
        m0.ack   = active && !own1 && s.ack;
        m0.err   = active && !own1 && s.err;
        m1.ack   = active && own1 && s.ack;
        m1.err   = active && own1 && s.err;
        m0.dat_r = s.dat_r;
        m1.dat_r = s.dat_r;
        gnt      = {state_q == OWN1, state_q == OWN0};
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            hold_q  <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
            drop_q  <= drop_d;
        end
    end
endmodule

// File: tb/tb_wshb_arbiter.sv
// tb_wshb_arbiter: directed bench with a cycle-level ownership model checked every
// negative edge, plus literal expectations for each scenario.
module tb_wshb_arbiter;
    localparam int MAXH = 64;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic [1:0]  gnt;
    logic        c [2];
    logic        st [2];
    logic        we [2];
    logic [31:0] a [2];
    logic [31:0] dw [2];
    logic [2:0]  ct [2];
    logic [31:0] rdat;
    int          n_chk = 0, n_fail = 0, nack0 = 0, nack1 = 0;
    int          own = -1, last = 1, beats = 0;
    bit          drop = 1'b0;

    wshb_if #(.AW(32), .DW(32)) m0_if ();
    wshb_if #(.AW(32), .DW(32)) m1_if ();
    wshb_if #(.AW(32), .DW(32)) s_if ();

    assign m0_if.cyc = c[0];   assign m1_if.cyc = c[1];
    assign m0_if.stb = st[0];  assign m1_if.stb = st[1];
    assign m0_if.we = we[0];   assign m1_if.we = we[1];
    assign m0_if.adr = a[0];   assign m1_if.adr = a[1];
    assign m0_if.dat_w = dw[0]; assign m1_if.dat_w = dw[1];
    assign m0_if.sel = 4'hF;   assign m1_if.sel = 4'hF;
    assign m0_if.cti = ct[0];  assign m1_if.cti = ct[1];
    assign m0_if.bte = 2'b00;  assign m1_if.bte = 2'b00;
    assign s_if.ack = s_if.cyc & s_if.stb;
    assign s_if.err = 1'b0;
    assign s_if.dat_r = rdat;

    wshb_arbiter #(.MAX_HOLD(MAXH), .AW(32), .DW(32)) dut (
        .clk(clk), .nrst(nrst), .m0(m0_if), .m1(m1_if), .s(s_if), .gnt(gnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Ownership model: who holds the bus, how many beats it has had, and the idle gap.
    initial forever begin
        int x, y, nb;
        bit acked;
        @(posedge clk or negedge nrst);
        if (!nrst) begin
            own = -1; last = 1; beats = 0; drop = 1'b0;
        end else if (own < 0) begin
            if (c[0] && c[1]) own = 1 - last;
            else if (c[0]) own = 0;
            else if (c[1]) own = 1;
        end else begin
            x = own; y = 1 - own;
            acked = !drop && c[x] && st[x];
            if (drop || !c[x]) begin
                last = x; beats = 0;
                own = c[y] ? y : (drop && c[x]) ? x : -1;
                drop = 1'b0;
            end else begin
                nb = beats + int'(acked);
                beats = nb > MAXH ? MAXH : nb;
                drop = beats == MAXH && c[y] && (!st[x] || (acked && (ct[x] == 3'd0 || ct[x] == 3'd7)));
            end
        end
    end

    initial forever begin
        int x;
        bit act;
        @(negedge clk);
        if (m0_if.ack) nack0++;
        if (m1_if.ack) nack1++;
        if (!nrst) begin
            chk("rst_gnt", gnt, 0);
            chk("rst_s_cyc", s_if.cyc, 0);
        end else begin
            x = own < 0 ? 0 : own;
            act = own >= 0 && !drop;
            chk("gnt", gnt, own == 0 ? 32'd1 : own == 1 ? 32'd2 : 32'd0);
            chk("s_cyc", s_if.cyc, act && c[x]);
            chk("s_stb", s_if.stb, act && st[x]);
            chk("s_we", s_if.we, act && we[x]);
            chk("s_adr", s_if.adr, act ? a[x] : 32'd0);
            chk("s_cti", s_if.cti, act ? ct[x] : 3'd0);
            chk("m0_ack", m0_if.ack, act && x == 0 && c[0] && st[0]);
            chk("m1_ack", m1_if.ack, act && x == 1 && c[1] && st[1]);
            chk("m0_dat_r", m0_if.dat_r, rdat);
            chk("m1_dat_r", m1_if.dat_r, rdat);
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic run(input int m, input int n, input bit burst, input bit dropc, input string nm);
        int k = 0, t = 0;
        c[m] = 1'b1; st[m] = 1'b1;
        ct[m] = burst ? (n == 1 ? 3'd7 : 3'd2) : 3'd0;
        while (k < n && t < 500) begin
            @(negedge clk);
            t++;
            if (m == 0 ? m0_if.ack : m1_if.ack) begin
                k++;
                tick();
                a[m] += 4; dw[m]++;
                ct[m] = burst ? (k == n - 1 ? 3'd7 : 3'd2) : 3'd0;
            end
        end
        chk({nm, "_beats"}, k, n);
        if (dropc) begin c[m] = 1'b0; st[m] = 1'b0; end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, required finish before 100us");
        $fatal(1);
    end

    initial begin
        int n0, n1, t;
        bit gap;
        for (int i = 0; i < 2; i++) begin
            c[i] = 1'b0; st[i] = 1'b0; we[i] = 1'b0; ct[i] = 3'd0; dw[i] = 32'd0;
        end
        a[0] = 32'h0000_0100; a[1] = 32'h0000_8000; rdat = 32'h1234_5678;
        // reset held with m0 already requesting
        c[0] = 1'b1;
        #50;
        chk("t1_rst_gnt", gnt, 0);
        chk("t1_rst_s_cyc", s_if.cyc, 0);
        #78 nrst = 1'b1;
        tick();
        chk("t1_first_gnt", gnt, 2'b01);
        c[0] = 1'b0;
        tick(2);
        // simultaneous request straight after reset: m0 wins, direct handoff to m1
        nrst = 1'b0; tick(); nrst = 1'b1; tick();
        we[0] = 1'b1; we[1] = 1'b0;
        c[0] = 1'b1; st[0] = 1'b1; c[1] = 1'b1; st[1] = 1'b1;
        tick();
        chk("t2_m0_first", gnt, 2'b01);
        run(0, 4, 1'b0, 1'b1, "t2_m0");
        tick();
        chk("t2_handoff", gnt, 2'b10);
        run(1, 3, 1'b0, 1'b1, "t2_m1");
        tick(2);
        chk("t2_idle", gnt, 2'b00);
        // long m0 write stream pre-empted after MAX_HOLD beats
        c[0] = 1'b1; st[0] = 1'b1;
        tick();
        chk("t3_gnt0", gnt, 2'b01);
        n0 = nack0;
        c[1] = 1'b1; st[1] = 1'b0;
        gap = 1'b0; t = 0;
        while (gnt !== 2'b10 && t < 300) begin
            @(negedge clk);
            t++;
            if (gnt == 2'b01 && !s_if.cyc) gap = 1'b1;
        end
        tick();
        chk("t3_m0_acks", nack0 - n0, MAXH);
        chk("t3_gap", gap, 1);
        chk("t3_gnt1", gnt, 2'b10);
        n0 = nack0;
        run(1, 5, 1'b0, 1'b1, "t3_m1");
        tick();
        chk("t3_m0_stalled", nack0 - n0, 0);
        chk("t3_back0", gnt, 2'b01);
        c[0] = 1'b0; st[0] = 1'b0;
        tick(2);
        // m1 incrementing burst crossing MAX_HOLD completes before the handoff
        we[1] = 1'b0;
        run(1, 60, 1'b0, 1'b0, "t4_m1_classic");
        c[0] = 1'b1; st[0] = 1'b1;
        n1 = nack1;
        run(1, 8, 1'b1, 1'b0, "t4_m1_burst");
        st[1] = 1'b0;
        chk("t4_burst_acks", nack1 - n1, 8);
        chk("t4_gap_gnt", gnt, 2'b10);
        chk("t4_gap_s_cyc", s_if.cyc, 0);
        tick();
        chk("t4_gnt0", gnt, 2'b01);
        c[1] = 1'b0;
        c[0] = 1'b0; st[0] = 1'b0;
        tick(2);
        // m1 read data path
        rdat = 32'hCAFE_0001;
        c[1] = 1'b1; st[1] = 1'b1;
        t = 0;
        while (!m1_if.ack && t < 20) begin @(negedge clk); t++; end
        chk("t5_m1_ack", m1_if.ack, 1);
        chk("t5_m1_dat_r", m1_if.dat_r, 32'hCAFE_0001);
        chk("t5_m0_ack", m0_if.ack, 0);
        tick();
        c[1] = 1'b0; st[1] = 1'b0;
        tick(2);
        // reset in the middle of an m0 burst, then a tie after release
        we[0] = 1'b1; c[0] = 1'b1; st[0] = 1'b1; ct[0] = 3'd2;
        tick(4);
        nrst = 1'b0;
        #1;
        chk("t6_s_cyc", s_if.cyc, 0);
        chk("t6_gnt", gnt, 2'b00);
        chk("t6_hold", 32'(dut.hold_q), 0);
        c[1] = 1'b1;
        tick();
        nrst = 1'b1;
        tick();
        chk("t6_tie_m0", gnt, 2'b01);
        c[0] = 1'b0; st[0] = 1'b0; c[1] = 1'b0; ct[0] = 3'd0;
        tick(3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/wshb_arbiter.md
Name: wshb_arbiter

Overview:
- Two-master, one-slave Wishbone B4 arbiter. It shares the SDRAM Wishbone port between two masters.
- Master 0 is the pattern/mire writer. Master 1 is the video controller framebuffer reader.
- It sits in Top between those two masters and the hws_if SDRAM bridge.
- Grants are round-robin with a bounded hold time, so that video refill can never be starved by a long writer burst.

Parameters:
- MAX_HOLD, 64: number of acked beats after which the current owner is pre-empted, provided the other master is requesting.
- AW, 32: address width.
- DW, 32: data width. The sel width is DW/8.

Ports:
- clk  in  1  system clock; every register is in this domain.
- nrst  in  1  asynchronous active-low reset.
- m0_cyc, m0_stb, m0_we  in  1 each  master 0 Wishbone controls.
- m0_adr  in  AW  master 0 address.
- m0_dat_w  in  DW  master 0 write data.
- m0_sel  in  DW/8  master 0 byte selects.
- m0_cti  in  3  master 0 cycle type.
- m0_bte  in  2  master 0 burst type.
- m0_ack, m0_err  out  1 each  master 0 response.
- m0_dat_r  out  DW  master 0 read data.
- m1_* (same set as m0_*)  master 1, identical directions and widths.
- s_cyc, s_stb, s_we  out  1 each  slave controls.
- s_adr  out  AW  slave address.
- s_dat_w  out  DW  slave write data.
- s_sel  out  DW/8  slave byte selects.
- s_cti  out  3  slave cycle type.
- s_bte  out  2  slave burst type.
- s_ack, s_err  in  1 each  slave response.
- s_dat_r  in  DW  slave read data.
- gnt  out  2  one-hot current owner (debug and LED visibility).

Behaviour:
- FSM states: IDLE, OWN0, OWN1. State register `last` (0/1) records the last-served master. Counter `hold` is $clog2(MAX_HOLD+1) bits wide.
- Reset values (async on nrst=0):
  - state=IDLE, last=1 (master 0 wins the first tie), hold=0, gnt=2'b00.
  - Every s_* output is 0 and every m*_ack/m*_err is 0.
  - Reset mid-transfer aborts immediately; s_cyc falls in the same instant.
- IDLE:
  - Request means mX_cyc=1.
  - One requester: go to its OWN state on the next edge.
  - Both requesting: go to OWN of the master != last.
  - Arbitration latency is 1 cycle from cyc assertion to grant.
- OWNx, forwarding:
  - s_cyc, s_stb, s_we, s_adr, s_dat_w, s_sel, s_cti and s_bte are combinationally muxed from master x.
  - s_ack/s_err are routed to mx_ack/mx_err only. The non-owner sees ack=err=0.
  - s_dat_r is broadcast to both mX_dat_r.
- OWNx, beat accounting: hold increments on each s_ack or s_err and saturates at MAX_HOLD.
- OWNx, release: when mx_cyc=0, the FSM goes as follows on the next edge, with hold cleared and last=x:
  - to OWNy if my_cyc=1 (direct handoff, no IDLE bubble);
  - otherwise to IDLE.
- OWNx, pre-emption:
  - Condition: hold==MAX_HOLD, my_cyc=1, and the current beat is at a burst boundary. A boundary means the acked beat had cti=3'b000 or 3'b111, or no beat is in flight (s_stb=0).
  - On the condition: s_stb is forced to 0 from the next cycle, s_cyc falls for one cycle, then the FSM enters OWNy with hold=0 and last=x.
  - Master x simply stalls (stb held, no ack) until it is re-granted.
  - Pre-emption never splits an incrementing burst (cti=3'b010) mid-burst.
- Simultaneous events: master x dropping cyc in the same cycle as the pre-emption condition is treated as a normal release.
- s_cyc is never high with gnt=2'b00.
- gnt always equals the one-hot form of state (00 in IDLE).
- Arithmetic: no wrap on hold. MAX_HOLD=0 is illegal and is flagged by an elaboration assertion.
- Slave err is passed through like ack. It does not change arbitration.

Test Plan:
- Reset with m0_cyc=1, then release nrst at t=128 ns → gnt=00 during reset; gnt=01 exactly 1 cycle after the first edge with m0_cyc seen; s_cyc=0 while nrst=0.
- m0 and m1 raise cyc on the same edge → m0 is granted first; once m0 drops cyc after 4 acked classic beats, gnt=10 on the next edge with no IDLE cycle; m1 is served after that.
- m0 holds cyc with continuous classic writes, MAX_HOLD=64, m1 requesting → m0 gets exactly 64 acks; one cycle with s_cyc=0; gnt=10; m0_ack=0 for the whole m1 tenure.
- m1 runs a cti=010 burst of 8 beats that spans hold reaching MAX_HOLD, m0 requesting → all 8 beats complete, ending with cti=111, before the handoff to m0.
- m1 read, slave returns s_dat_r=32'hCAFE_0001 with s_ack → m1_ack=1 and m1_dat_r=CAFE_0001; m0_ack=0.
- Assert nrst=0 in the middle of an m0 burst → s_cyc=0, gnt=00 and hold=0 immediately; after release, arbitration restarts with m0 winning a tie (last=1).
